// File: rtl/start_fifo_pkg.sv
// Shared types and helpers for the start-token SRL FIFO controller.
package start_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_e;

  // Bits needed to address 'value' entries; used for parameter sanity checks.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/start_fifo_srl_storage.sv
// Shift-register token storage: push shifts din into slot 0, dout reads slot addr.
module start_fifo_srl_storage #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_q;

  // Contents deliberately unreset so the array can map onto SRL primitives.
  always_ff @(posedge clk) begin
    if (we) sr_q <= {sr_q[DEPTH-2:0], din};
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) dout = sr_q[i];
    end
  end

endmodule

// File: rtl/start_fifo_srl_ctrl.sv
// Start-token FIFO controller: owns occupancy, read address and registered
// full_n/empty_n flags for an SRL-based shift-register store.
module start_fifo_srl_ctrl
  import start_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("start_fifo_srl_ctrl: DEPTH must be at least 2");
  end
  if (ADDR_WIDTH < clog2(DEPTH)) begin : g_bad_addr
    $error("start_fifo_srl_ctrl: ADDR_WIDTH too small for DEPTH");
  end

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [ADDR_WIDTH:0]   count_q,   count_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q,  full_n_d;

  logic push;
  logic pop;

  // Both handshakes are gated by the registered flags: no bypass in either direction.
  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read  & if_read_ce  & empty_n_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    empty_n_d = empty_n_q;
    full_n_d  = full_n_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d   = PARTIAL;
          addr_d    = '0;
          count_d   = CNT_ONE;
          empty_n_d = 1'b1;
        end
      end
      PARTIAL: begin
        if (push && !pop) begin
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_q + CNT_ONE;
          if (count_q == CNT_LAST) begin
            state_d  = FULL;
            full_n_d = 1'b0;
          end
        end else if (pop && !push) begin
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d   = EMPTY;
            addr_d    = '0;
            empty_n_d = 1'b0;
          end else begin
            addr_d = addr_q - ADDR_ONE;
          end
        end
        // push & pop together: the shift alone advances the queue.
      end
      FULL: begin
        if (pop) begin
          state_d  = PARTIAL;
          addr_d   = addr_q - ADDR_ONE;
          count_d  = count_q - CNT_ONE;
          full_n_d = 1'b1;
        end
      end
      default: begin
        state_d   = EMPTY;
        addr_d    = '0;
        count_d   = '0;
        empty_n_d = 1'b0;
        full_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      addr_q    <= '0;
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  start_fifo_srl_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (push),
    .addr (addr_q),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;

  a_addr_range: assert property (@(posedge clk) disable iff (reset)
    int'(addr_q) <= DEPTH - 1);

endmodule
